// File: rtl/sram_wr_ctrl_pkg.sv
// Shared display constants, controller state encoding and cursor helpers.
package sram_wr_ctrl_pkg;

  localparam int RGB565_W       = 16;
  localparam int DISP_W_DEFAULT = 160;
  localparam int DISP_H_DEFAULT = 128;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_CLEAR = 1'b1
  } state_t;

  typedef struct packed {
    logic [15:0] xs;
    logic [15:0] xe;
    logic [15:0] ys;
    logic [15:0] ye;
  } window_t;

  typedef struct packed {
    logic [15:0] cx;
    logic [15:0] cy;
  } cursor_t;

  // Raster step inside the window; all arithmetic wraps at 16 bits.
  function automatic cursor_t cursor_next(input cursor_t c, input window_t w);
    cursor_t n;
    n = c;
    if (c.cx != w.xe) begin
      n.cx = c.cx + 16'd1;
    end else begin
      n.cx = w.xs;
      n.cy = (c.cy == w.ye) ? w.ys : c.cy + 16'd1;
    end
    return n;
  endfunction

endpackage

// File: rtl/sram_wr_ctrl_if.sv
// SRAM write-port bundle: valid/ready request carrying a word address and RGB565 data.
interface sram_wr_ctrl_if
  import sram_wr_ctrl_pkg::*;
#(
  parameter int ADDR_W = 15
);
  logic                o_wr_valid;
  logic                i_wr_ready;
  logic [ADDR_W-1:0]   o_wr_addr;
  logic [RGB565_W-1:0] o_wr_data;

  modport master (output o_wr_valid, output o_wr_addr, output o_wr_data, input i_wr_ready);
  modport slave  (input o_wr_valid, input o_wr_addr, input o_wr_data, output i_wr_ready);
endinterface

// File: rtl/sync_fifo.sv
// Show-ahead synchronous FIFO; dout is the head entry whenever not empty.
// Push on a full FIFO succeeds only if a pop happens the same cycle; flush empties it.
module sync_fifo #(
  parameter int WIDTH = 31,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush_i,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [WIDTH-1:0] din_i,
  output logic [WIDTH-1:0] dout_o,
  output logic             empty_o,
  output logic             full_o
);
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PTR_W:0] FULL_CNT = (PTR_W + 1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [PTR_W:0]   cnt_q;
  logic             push_ok, pop_ok;

  assign empty_o = (cnt_q == '0);
  assign full_o  = (cnt_q == FULL_CNT);
  assign pop_ok  = pop_i && !empty_o;
  assign push_ok = push_i && (!full_o || pop_ok);
  assign dout_o  = mem_q[rd_ptr_q];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else if (flush_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop_ok)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   cnt_q <= cnt_q + 1'b1;
        2'b01:   cnt_q <= cnt_q - 1'b1;
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok && !flush_i) mem_q[wr_ptr_q] <= din_i;
  end

endmodule

// File: rtl/sram_wr_ctrl.sv
// Pixel write controller: windowed cursor addressing into a show-ahead FIFO plus full-frame clear.
// SRAM port is valid/ready; a pixel arriving on a full FIFO with no pop is dropped and flagged.
module sram_wr_ctrl
  import sram_wr_ctrl_pkg::*;
#(
  parameter int DISP_W     = DISP_W_DEFAULT,
  parameter int DISP_H     = DISP_H_DEFAULT,
  parameter int ADDR_W     = 15,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic [RGB565_W-1:0] i_pixel_data,
  input  logic [31:0]         i_col_addr,
  input  logic [31:0]         i_row_addr,
  input  logic                i_sram_clr_req,
  input  logic                i_sram_write_req,
  input  logic                i_sram_waddr_set_req,
  sram_wr_ctrl_if.master      wr,
  output logic                o_busy,
  output logic                o_overflow
);
  localparam int                ENTRY_W   = ADDR_W + RGB565_W;
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DISP_W * DISP_H - 1);
  localparam logic [15:0]       X_LIM     = 16'(DISP_W);
  localparam logic [15:0]       Y_LIM     = 16'(DISP_H);

  state_t              state_q, state_d;
  cursor_t             cur_q, cur_d;
  logic [ADDR_W-1:0]   cnt_q, cnt_d;
  logic                ovf_q, ovf_d;
  window_t             win;
  logic                wr_accept, in_range, push, pop, flush, drop;
  logic [ADDR_W-1:0]   pix_addr, head_addr;
  logic [RGB565_W-1:0] head_data;
  logic [ENTRY_W-1:0]  fifo_dout;
  logic                fifo_empty, fifo_full;
  logic                wr_valid;
  logic [ADDR_W-1:0]   wr_addr;
  logic [RGB565_W-1:0] wr_data;

  assign win       = window_t'({i_col_addr, i_row_addr});
  assign wr_accept = i_sram_write_req && (state_q == ST_IDLE);
  assign in_range  = (cur_q.cx < X_LIM) && (cur_q.cy < Y_LIM);
  assign push      = wr_accept && in_range;
  assign drop      = push && fifo_full && !pop;
  // Truncating operands first yields the same low ADDR_W bits as the full product.
  assign pix_addr  = ADDR_W'(cur_q.cy) * ADDR_W'(DISP_W) + ADDR_W'(cur_q.cx);
  assign {head_addr, head_data} = fifo_dout;

  sync_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (i_clk),
    .rst     (i_rst),
    .flush_i (flush),
    .push_i  (push),
    .pop_i   (pop),
    .din_i   ({pix_addr, i_pixel_data}),
    .dout_o  (fifo_dout),
    .empty_o (fifo_empty),
    .full_o  (fifo_full)
  );

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q <= ST_IDLE;
      cur_q   <= '0;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cur_q   <= cur_d;
      cnt_q   <= cnt_d;
      ovf_q   <= ovf_d;
    end
  end

  // A set pulse wins over the advance caused by a simultaneous write.
  always_comb begin
    cur_d = cur_q;
    if (i_sram_waddr_set_req) begin
      cur_d.cx = win.xs;
      cur_d.cy = win.ys;
    end else if (wr_accept) begin
      cur_d = cursor_next(cur_q, win);
    end
  end

  assign ovf_d = i_sram_clr_req ? 1'b0 : (ovf_q | drop);

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    flush    = 1'b0;
    pop      = 1'b0;
    wr_valid = 1'b0;
    wr_addr  = '0;
    wr_data  = '0;
    case (state_q)
      ST_IDLE: begin
        wr_valid = !fifo_empty;
        wr_addr  = fifo_empty ? '0 : head_addr;
        wr_data  = fifo_empty ? '0 : head_data;
        pop      = wr_valid && wr.i_wr_ready;
        if (i_sram_clr_req) begin
          state_d = ST_CLEAR;
          cnt_d   = '0;
          flush   = 1'b1;
        end
      end
      ST_CLEAR: begin
        wr_valid = 1'b1;
        wr_addr  = cnt_q;
        if (i_sram_clr_req) begin
          cnt_d = '0;
        end else if (wr.i_wr_ready) begin
          if (cnt_q == LAST_ADDR) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign wr.o_wr_valid = wr_valid;
  assign wr.o_wr_addr  = wr_addr;
  assign wr.o_wr_data  = wr_data;
  assign o_busy        = (state_q == ST_CLEAR) || !fifo_empty;
  assign o_overflow    = ovf_q;

endmodule
